// File: rtl/cdb_result_queue_pkg.sv
// Shared CDB definitions: result width, tag width, default queue depth and the
// broadcast entry type carried from a functional unit to the CDB arbiter.
package cdb_result_queue_pkg;

    localparam int unsigned XLEN         = 32;
    localparam int unsigned CDB_TAG_W    = 3;
    localparam int unsigned CDB_RQ_DEPTH = 4;

    typedef struct packed {
        logic [CDB_TAG_W-1:0] tag;
        logic [XLEN-1:0]      value;
    } CDB_ENTRY;

endpackage

// File: rtl/cdb_result_queue.sv
// Per-FU show-ahead completion FIFO between a functional unit and the CDB
// arbiter; back-pressures the FU so a lost arbitration never drops a result.
module cdb_result_queue
    import cdb_result_queue_pkg::*;
#(
    parameter  int unsigned DEPTH = CDB_RQ_DEPTH,
    parameter  int unsigned TAG_W = CDB_TAG_W,
    localparam int unsigned CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clock_i,
    input  logic             reset_i,
    input  logic             squash_i,
    input  logic             fu_valid_i,
    input  logic [TAG_W-1:0] fu_tag_i,
    input  logic [XLEN-1:0]  fu_value_i,
    output logic             fu_ready_o,
    input  logic             cdb_clear_i,
    output logic             done_o,
    output logic [TAG_W-1:0] head_tag_o,
    output logic [XLEN-1:0]  head_value_o,
    output logic [CNT_W-1:0] count_o
);

    localparam int unsigned PTR_W = $clog2(DEPTH);

    typedef struct packed {
        logic [TAG_W-1:0] tag;
        logic [XLEN-1:0]  value;
    } entry_t;

    entry_t           mem_q [DEPTH];
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [CNT_W-1:0] count_q,  count_d;
    logic             push, pop;

    // fu_ready looks only at cdb_clear and state, never at fu_valid, so no loop.
    assign fu_ready_o = ~squash_i & ((count_q < CNT_W'(DEPTH)) | cdb_clear_i);
    assign done_o     = (count_q != '0);
    assign push       = fu_valid_i & fu_ready_o;
    assign pop        = cdb_clear_i & done_o;
    assign count_o    = count_q;

    always_comb begin
        head_tag_o   = '0;
        head_value_o = '0;
        if (done_o) begin
            head_tag_o   = mem_q[rd_ptr_q].tag;
            head_value_o = mem_q[rd_ptr_q].value;
        end
    end

    always_comb begin
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        if (squash_i) begin
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
            if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
            if (push && !pop)      count_d = count_q + CNT_W'(1);
            else if (pop && !push) count_d = count_q - CNT_W'(1);
        end
    end

    always_ff @(posedge clock_i or negedge reset_i) begin
        if (!reset_i) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage carries no reset; count alone decides which slots are live.
    always_ff @(posedge clock_i) begin
        if (push) mem_q[wr_ptr_q] <= '{tag: fu_tag_i, value: fu_value_i};
    end

    a_full_push_needs_pop: assert property (@(posedge clock_i) disable iff (!reset_i)
        (push && count_q == CNT_W'(DEPTH)) |-> pop);
    a_count_bound: assert property (@(posedge clock_i) disable iff (!reset_i)
        count_q <= CNT_W'(DEPTH));
    a_done_known: assert property (@(posedge clock_i) disable iff (!reset_i)
        !$isunknown(done_o));

endmodule

// File: tb/tb_cdb_result_queue.sv
// Scoreboard bench for cdb_result_queue: the driver queues expected results as
// it issues accepted pushes, a negedge monitor checks every granted broadcast.
module tb_cdb_result_queue;
    import cdb_result_queue_pkg::*;

    localparam int unsigned DEPTH = 4;
    localparam int unsigned TAG_W = 3;
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);

    logic             clock_i = 1'b0;
    logic             reset_i;
    logic             squash_i;
    logic             fu_valid_i;
    logic [TAG_W-1:0] fu_tag_i;
    logic [XLEN-1:0]  fu_value_i;
    logic             fu_ready_o;
    logic             cdb_clear_i;
    logic             done_o;
    logic [TAG_W-1:0] head_tag_o;
    logic [XLEN-1:0]  head_value_o;
    logic [CNT_W-1:0] count_o;

    cdb_result_queue #(.DEPTH(DEPTH), .TAG_W(TAG_W)) dut (
        .clock_i     (clock_i),
        .reset_i     (reset_i),
        .squash_i    (squash_i),
        .fu_valid_i  (fu_valid_i),
        .fu_tag_i    (fu_tag_i),
        .fu_value_i  (fu_value_i),
        .fu_ready_o  (fu_ready_o),
        .cdb_clear_i (cdb_clear_i),
        .done_o      (done_o),
        .head_tag_o  (head_tag_o),
        .head_value_o(head_value_o),
        .count_o     (count_o)
    );

    always #5 clock_i = ~clock_i;

    typedef struct {
        logic [TAG_W-1:0] tag;
        logic [XLEN-1:0]  value;
    } exp_t;

    exp_t sb[$];
    int   errors = 0;
    int   checks = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: every granted broadcast must match the oldest outstanding result.
    always @(negedge clock_i) begin
        if (reset_i === 1'b1 && done_o === 1'b1 && cdb_clear_i === 1'b1) begin
            if (sb.size() == 0) begin
                chk("bcast_unexpected", 64'(head_tag_o), 64'hFFFF);
            end else begin
                chk("bcast_tag",   64'(head_tag_o),   64'(sb[0].tag));
                chk("bcast_value", 64'(head_value_o), 64'(sb[0].value));
                void'(sb.pop_front());
            end
        end
        if (squash_i === 1'b1) sb.delete();
    end

    // Called at posedge+1; leaves at the next posedge+1 after the edge has taken the inputs.
    task automatic step(input logic v, input logic [TAG_W-1:0] tag, input logic [XLEN-1:0] val,
                        input logic clr, input logic sq, input logic exp_rdy);
        fu_valid_i  = v;
        fu_tag_i    = tag;
        fu_value_i  = val;
        cdb_clear_i = clr;
        squash_i    = sq;
        #3;
        chk("fu_ready", 64'(fu_ready_o), 64'(exp_rdy));
        if (v && exp_rdy) sb.push_back('{tag: tag, value: val});
        @(posedge clock_i);
        #1;
    endtask

    task automatic idle();
        step(1'b0, '0, '0, 1'b0, 1'b0, 1'b1);
    endtask

    task automatic expect_state(input string name, input int cnt, input logic dn,
                                input logic [TAG_W-1:0] htag, input logic [XLEN-1:0] hval);
        chk({name, "_count"}, 64'(count_o),      64'(cnt));
        chk({name, "_done"},  64'(done_o),       64'(dn));
        chk({name, "_htag"},  64'(head_tag_o),   64'(htag));
        chk({name, "_hval"},  64'(head_value_o), 64'(hval));
    endtask

    initial begin
        reset_i     = 1'b0;
        squash_i    = 1'b0;
        fu_valid_i  = 1'b0;
        fu_tag_i    = '0;
        fu_value_i  = '0;
        cdb_clear_i = 1'b0;
        repeat (2) @(posedge clock_i);
        #1;
        expect_state("reset0", 0, 1'b0, '0, '0);
        chk("reset0_ready", 64'(fu_ready_o), 64'd1);
        reset_i = 1'b1;
        @(posedge clock_i);
        #1;

        // 1: async reset in the middle of traffic
        step(1'b1, 3'd1, 32'h11, 1'b0, 1'b0, 1'b1);
        step(1'b1, 3'd2, 32'h22, 1'b0, 1'b0, 1'b1);
        step(1'b1, 3'd3, 32'h33, 1'b0, 1'b0, 1'b1);
        fu_valid_i = 1'b0;
        expect_state("pre_rst", 3, 1'b1, 3'd1, 32'h11);
        #2;
        reset_i = 1'b0;
        #1;
        expect_state("async_rst", 0, 1'b0, '0, '0);
        chk("async_rst_ready", 64'(fu_ready_o), 64'd1);
        sb.delete();
        @(negedge clock_i);
        reset_i = 1'b1;
        @(posedge clock_i);
        #1;

        // 2: fill to full, extra push refused
        step(1'b1, 3'd1, 32'h11, 1'b0, 1'b0, 1'b1);
        step(1'b1, 3'd2, 32'h22, 1'b0, 1'b0, 1'b1);
        step(1'b1, 3'd3, 32'h33, 1'b0, 1'b0, 1'b1);
        step(1'b1, 3'd4, 32'h44, 1'b0, 1'b0, 1'b1);
        expect_state("full", 4, 1'b1, 3'd1, 32'h11);
        step(1'b1, 3'd5, 32'h55, 1'b0, 1'b0, 1'b0);
        expect_state("full_refuse", 4, 1'b1, 3'd1, 32'h11);

        // 3: push and pop together while full
        step(1'b1, 3'd5, 32'h55, 1'b1, 1'b0, 1'b1);
        expect_state("full_pp", 4, 1'b1, 3'd2, 32'h22);
        for (int i = 0; i < 4; i++) step(1'b0, '0, '0, 1'b1, 1'b0, 1'b1);
        expect_state("drained", 0, 1'b0, '0, '0);

        // 4: pointer wrap-around with occupancy held at one
        step(1'b1, 3'd0, 32'hA0, 1'b0, 1'b0, 1'b1);
        expect_state("wrap_prime", 1, 1'b1, 3'd0, 32'hA0);
        for (int i = 1; i < 10; i++) begin
            step(1'b1, 3'(i % 8), 32'hA0 + 32'(i), 1'b1, 1'b0, 1'b1);
            chk("wrap_count", 64'(count_o), 64'd1);
            chk("wrap_htag", 64'(head_tag_o), 64'(i % 8));
        end
        step(1'b0, '0, '0, 1'b1, 1'b0, 1'b1);
        expect_state("wrap_end", 0, 1'b0, '0, '0);

        // 5: squash dominates push and pop in the same cycle
        step(1'b1, 3'd1, 32'h101, 1'b0, 1'b0, 1'b1);
        step(1'b1, 3'd2, 32'h202, 1'b0, 1'b0, 1'b1);
        step(1'b1, 3'd3, 32'h303, 1'b0, 1'b0, 1'b1);
        expect_state("pre_squash", 3, 1'b1, 3'd1, 32'h101);
        step(1'b1, 3'd7, 32'h77, 1'b1, 1'b1, 1'b0);
        expect_state("squash", 0, 1'b0, '0, '0);
        idle();
        expect_state("post_squash", 0, 1'b0, '0, '0);

        // 6: grant while empty is ignored
        step(1'b0, '0, '0, 1'b1, 1'b0, 1'b1);
        expect_state("spurious", 0, 1'b0, '0, '0);
        step(1'b1, 3'd6, 32'h66, 1'b0, 1'b0, 1'b1);
        expect_state("after_spur", 1, 1'b1, 3'd6, 32'h66);
        step(1'b0, '0, '0, 1'b1, 1'b0, 1'b1);
        expect_state("final", 0, 1'b0, '0, '0);

        chk("sb_empty", 64'(sb.size()), 64'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
